// File: rtl/readout_sequencer_if.sv
// Event-control bundle between the BX source / merge datapath and readout_sequencer.
interface readout_sequencer_if #(
    parameter int BX_W   = 3,
    parameter int CNT_W  = 7,
    parameter int WORD_W = 7
);
    logic              bx_start;
    logic              none;
    logic              valid;
    logic              stats_clr;
    logic              new_event;
    logic [BX_W-1:0]   BX;
    logic [CNT_W-1:0]  clk_cnt;
    logic [BX_W-1:0]   BX_pipe;
    logic              busy;
    logic              done;
    logic              timeout;
    logic              truncated;
    logic [WORD_W-1:0] words_last;
    logic [7:0]        trunc_cnt;
    logic [7:0]        tmo_cnt;

    modport master (
        output bx_start, none, valid, stats_clr,
        input  new_event, BX, clk_cnt, BX_pipe, busy, done, timeout, truncated,
               words_last, trunc_cnt, tmo_cnt
    );

    modport slave (
        input  bx_start, none, valid, stats_clr,
        output new_event, BX, clk_cnt, BX_pipe, busy, done, timeout, truncated,
               words_last, trunc_cnt, tmo_cnt
    );
endinterface

// File: rtl/readout_sequencer.sv
// Per-event controller for the merge datapath: new_event, BX bookkeeping, readout window.
// Optional truncation/timeout statistics counters enabled by defining READOUT_STATS_EN.
module readout_sequencer #(
    parameter int BX_W      = 3,
    parameter int CNT_W     = 7,
    parameter int MAX_CLKS  = 100,
    parameter int SETUP_CYC = 3,
    parameter int WORD_W    = 7
) (
    input logic                clk,
    input logic                rst_n,
    readout_sequencer_if.slave bus
);
    typedef enum logic [1:0] {IDLE, SETUP, READOUT, DONE} state_t;

    localparam logic [CNT_W-1:0]  CNT_LAST   = CNT_W'(MAX_CLKS - 1);
    localparam logic [CNT_W-1:0]  SETUP_LAST = CNT_W'(SETUP_CYC - 1);
    localparam logic [WORD_W-1:0] WORD_MAX   = '1;

    state_t            state, state_nxt;
    logic [BX_W-1:0]   bx_next;
    logic [WORD_W-1:0] words;
    logic              in_readout, busy_s, at_last, tmo;

    assign in_readout = (state == READOUT);
    assign busy_s     = (state == SETUP) || in_readout;
    assign at_last    = (bus.clk_cnt == CNT_LAST);
    // none beats an expiring window in the same cycle
    assign tmo        = in_readout && !bus.none && at_last;

    assign bus.busy    = busy_s;
    assign bus.done    = (state == DONE);
    assign bus.timeout = tmo;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            SETUP:   if (bus.clk_cnt == SETUP_LAST) state_nxt = READOUT;
            READOUT: if (bus.none || at_last)       state_nxt = DONE;
            default: ;
        endcase
        if (bus.bx_start) state_nxt = SETUP;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.new_event  <= 1'b0;
            bus.truncated  <= 1'b0;
            bus.BX         <= '0;
            bus.BX_pipe    <= '0;
            bus.clk_cnt    <= '0;
            bus.words_last <= '0;
            bx_next        <= '0;
            words          <= '0;
        end else begin
            bus.new_event <= bus.bx_start;
            bus.truncated <= bus.bx_start && busy_s;
            if (bus.bx_start) begin
                bus.BX         <= bx_next;
                bx_next        <= bx_next + 1'b1;
                bus.clk_cnt    <= '0;
                bus.words_last <= words;
                words          <= '0;
            end else begin
                if (busy_s && !at_last) bus.clk_cnt <= bus.clk_cnt + 1'b1;
                // new_event marks clk_cnt==0, so this edge is where it becomes 1
                if (bus.new_event) bus.BX_pipe <= bus.BX;
                if (in_readout && bus.valid && words != WORD_MAX) words <= words + 1'b1;
            end
        end
    end

`ifdef READOUT_STATS_EN
    logic [7:0] trunc_q, tmo_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            trunc_q <= '0;
            tmo_q   <= '0;
        end else if (bus.stats_clr) begin
            trunc_q <= '0;
            tmo_q   <= '0;
        end else begin
            if (bus.truncated && trunc_q != 8'hFF) trunc_q <= trunc_q + 1'b1;
            if (tmo && tmo_q != 8'hFF)             tmo_q   <= tmo_q + 1'b1;
        end
    end

    assign bus.trunc_cnt = trunc_q;
    assign bus.tmo_cnt   = tmo_q;
`else
    logic unused_stats_clr;
    assign unused_stats_clr = bus.stats_clr;
    assign bus.trunc_cnt    = '0;
    assign bus.tmo_cnt      = '0;
`endif
endmodule

// File: tb/tb_readout_sequencer.sv
// Bench for readout_sequencer: directed table, corner sequences and random traffic
// against an event-age reference model.
module tb_readout_sequencer;
    localparam int BX_W = 3, CNT_W = 7, MAX_CLKS = 100, SETUP_CYC = 3, WORD_W = 7;
`ifdef READOUT_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    readout_sequencer_if #(.BX_W(BX_W), .CNT_W(CNT_W), .WORD_W(WORD_W)) bus ();

    readout_sequencer #(
        .BX_W(BX_W), .CNT_W(CNT_W), .MAX_CLKS(MAX_CLKS), .SETUP_CYC(SETUP_CYC), .WORD_W(WORD_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference model: an event is described by its age since new_event
    bit m_act, m_end, m_new, m_trunc;
    int m_age, m_ev, m_words, m_last, m_pipe, m_tc, m_oc;

    typedef struct {
        bit bx, nn, vl;
        bit new_e, busy, done;
        int bx_o, cnt, wl;
    } vec_t;
    vec_t tbl[15];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            if (n_err <= 50) $display("FAIL %s: got %0d, want %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit e_busy();
        return m_act && !m_end;
    endfunction
    function automatic bit e_rd();
        return e_busy() && m_age >= SETUP_CYC;
    endfunction
    function automatic int e_bx();
        return (m_ev == 0) ? 0 : (m_ev - 1) % (1 << BX_W);
    endfunction
    function automatic int e_cnt();
        return (m_age > MAX_CLKS - 1) ? MAX_CLKS - 1 : m_age;
    endfunction
    function automatic bit e_to();
        return e_rd() && !bus.none && m_age == MAX_CLKS - 1;
    endfunction

    task automatic model_reset();
        m_act = 0; m_end = 0; m_new = 0; m_trunc = 0;
        m_age = 0; m_ev = 0; m_words = 0; m_last = 0; m_pipe = 0; m_tc = 0; m_oc = 0;
    endtask

    task automatic drive(input bit bx, input bit nn, input bit vl, input bit clr);
        bus.bx_start = bx; bus.none = nn; bus.valid = vl; bus.stats_clr = clr;
        #1;
    endtask

    // Compare against the model, take one clock edge, advance the model.
    task automatic tick();
        bit busy, rd, to, tr;
        chk("new_event", bus.new_event, m_new);
        chk("busy", bus.busy, e_busy());
        chk("done", bus.done, m_act && m_end);
        chk("BX", bus.BX, e_bx());
        chk("clk_cnt", bus.clk_cnt, e_cnt());
        chk("BX_pipe", bus.BX_pipe, m_pipe);
        chk("timeout", bus.timeout, e_to());
        chk("truncated", bus.truncated, m_trunc);
        chk("words_last", bus.words_last, m_last);
        chk("trunc_cnt", bus.trunc_cnt, STATS ? m_tc : 0);
        chk("tmo_cnt", bus.tmo_cnt, STATS ? m_oc : 0);
        busy = e_busy(); rd = e_rd(); to = e_to(); tr = m_trunc;
        @(posedge clk);
        if (bus.stats_clr) begin
            m_tc = 0; m_oc = 0;
        end else begin
            if (tr && m_tc < 255) m_tc++;
            if (to && m_oc < 255) m_oc++;
        end
        if (bus.bx_start) begin
            m_new = 1; m_trunc = busy; m_last = m_words; m_words = 0;
            m_ev++; m_age = 0; m_end = 0; m_act = 1;
        end else begin
            m_new = 0; m_trunc = 0;
            if (busy) begin
                if (m_age == 0) m_pipe = e_bx();
                if (rd && bus.valid && m_words < (1 << WORD_W) - 1) m_words++;
                if (rd && (bus.none || m_age == MAX_CLKS - 1)) m_end = 1;
                m_age++;
            end
        end
        @(negedge clk);
    endtask

    task automatic cyc(input bit bx, input bit nn, input bit vl, input bit clr);
        drive(bx, nn, vl, clr);
        tick();
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, ".new_event"}, bus.new_event, 0);
        chk({tag, ".busy"}, bus.busy, 0);
        chk({tag, ".done"}, bus.done, 0);
        chk({tag, ".BX"}, bus.BX, 0);
        chk({tag, ".clk_cnt"}, bus.clk_cnt, 0);
        chk({tag, ".BX_pipe"}, bus.BX_pipe, 0);
        chk({tag, ".timeout"}, bus.timeout, 0);
        chk({tag, ".truncated"}, bus.truncated, 0);
        chk({tag, ".words_last"}, bus.words_last, 0);
        chk({tag, ".trunc_cnt"}, bus.trunc_cnt, 0);
        chk({tag, ".tmo_cnt"}, bus.tmo_cnt, 0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        drive(0, 0, 0, 0);
        model_reset();
        repeat (3) @(negedge clk);
        chk_zero("reset");
        rst_n = 1'b1;
    endtask

    // One full window with none never asserted; optional stats_clr on the expiring cycle.
    task automatic run_timeout(input bit clr_at_tmo);
        cyc(1, 0, 0, 0);
        repeat (MAX_CLKS - 1) cyc(0, 0, 0, 0);
        drive(0, 0, 0, clr_at_tmo);
        chk("tmo.pulse", bus.timeout, 1);
        chk("tmo.clk_cnt", bus.clk_cnt, MAX_CLKS - 1);
        tick();
        drive(0, 0, 0, 0);
        chk("tmo.done", bus.done, 1);
        chk("tmo.cnt_hold", bus.clk_cnt, MAX_CLKS - 1);
        chk("tmo.single", bus.timeout, 0);
        tick();
    endtask

    initial begin
        //        bx nn vl  new busy done  BX cnt wl
        tbl[0]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0};
        tbl[1]  = '{1, 0, 0, 0, 0, 0, 0, 0, 0};
        tbl[2]  = '{0, 0, 0, 1, 1, 0, 0, 0, 0};
        tbl[3]  = '{0, 0, 1, 0, 1, 0, 0, 1, 0};
        tbl[4]  = '{0, 1, 0, 0, 1, 0, 0, 2, 0};
        tbl[5]  = '{0, 0, 1, 0, 1, 0, 0, 3, 0};
        tbl[6]  = '{0, 0, 1, 0, 1, 0, 0, 4, 0};
        tbl[7]  = '{0, 0, 1, 0, 1, 0, 0, 5, 0};
        tbl[8]  = '{0, 0, 1, 0, 1, 0, 0, 6, 0};
        tbl[9]  = '{0, 0, 1, 0, 1, 0, 0, 7, 0};
        tbl[10] = '{0, 1, 0, 0, 1, 0, 0, 8, 0};
        tbl[11] = '{0, 0, 0, 0, 0, 1, 0, 9, 0};
        tbl[12] = '{0, 0, 0, 0, 0, 1, 0, 9, 0};
        tbl[13] = '{1, 0, 0, 0, 0, 1, 0, 9, 0};
        tbl[14] = '{0, 0, 0, 1, 1, 0, 1, 0, 5};

        @(negedge clk);
        do_reset();
        for (int i = 0; i < 15; i++) begin
            drive(tbl[i].bx, tbl[i].nn, tbl[i].vl, 0);
            chk($sformatf("tbl%0d.new_event", i), bus.new_event, tbl[i].new_e);
            chk($sformatf("tbl%0d.busy", i), bus.busy, tbl[i].busy);
            chk($sformatf("tbl%0d.done", i), bus.done, tbl[i].done);
            chk($sformatf("tbl%0d.BX", i), bus.BX, tbl[i].bx_o);
            chk($sformatf("tbl%0d.clk_cnt", i), bus.clk_cnt, tbl[i].cnt);
            chk($sformatf("tbl%0d.words_last", i), bus.words_last, tbl[i].wl);
            tick();
        end
        drive(0, 0, 0, 0);
        chk("pipe.after_ev1", bus.BX_pipe, 1);
        tick();

        // Truncation from READOUT
        repeat (5) cyc(0, 0, 0, 0);
        cyc(1, 0, 0, 0);
        drive(0, 0, 0, 0);
        chk("trunc.pulse", bus.truncated, 1);
        chk("trunc.BX", bus.BX, 2);
        tick();
        drive(0, 0, 0, 0);
        chk("trunc.single", bus.truncated, 0);
        chk("trunc.cnt", bus.trunc_cnt, STATS ? 1 : 0);
        tick();

        // Restart from SETUP, then back-to-back strobes
        cyc(1, 0, 1, 0);
        cyc(1, 0, 0, 0);
        drive(0, 0, 1, 0);
        chk("b2b.new_event", bus.new_event, 1);
        chk("b2b.truncated", bus.truncated, 1);
        chk("b2b.BX", bus.BX, 4);
        tick();
        repeat (9) cyc(0, 0, 1, 0);
        cyc(0, 1, 0, 0);
        cyc(1, 0, 0, 0);
        drive(0, 0, 0, 0);
        chk("restart.words_last", bus.words_last, 7);
        tick();

        // Asynchronous reset in the middle of SETUP
        cyc(0, 0, 0, 0);
        rst_n = 1'b0;
        #1;
        chk_zero("midreset");
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;

        // Nine events: BX wraps 0..7,0
        for (int i = 0; i < 9; i++) begin
            cyc(1, 0, 0, 0);
            drive(0, 1, 0, 0);
            chk($sformatf("wrap%0d.BX", i), bus.BX, i % 8);
            tick();
            repeat (5) cyc(0, 1, 0, 0);
        end

        // none and expiry together: none wins
        cyc(1, 0, 0, 0);
        repeat (MAX_CLKS - 1) cyc(0, 0, 0, 0);
        drive(0, 1, 0, 0);
        chk("tie.no_timeout", bus.timeout, 0);
        tick();

        // Timeout statistics saturate, clear wins over a same-cycle increment
        for (int k = 0; k < 300; k++) run_timeout(1'b0);
        drive(0, 0, 0, 0);
        chk("tmo.sat", bus.tmo_cnt, STATS ? 255 : 0);
        tick();
        run_timeout(1'b1);
        drive(0, 0, 0, 0);
        chk("tmo.clr", bus.tmo_cnt, 0);
        tick();

        // Random traffic against the model
        for (int i = 0; i < 4000; i++)
            cyc($urandom_range(0, 39) == 0, $urandom_range(0, 15) == 0,
                $urandom_range(0, 1) == 1, $urandom_range(0, 63) == 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
